// File: rtl/gpio_pad_ctrl.sv
// GPIO bank controller: register file, pad cell configuration/drive, and an
// input path with synchroniser, settle-qualified edge detection and a level interrupt.
module gpio_pad_ctrl #(
    parameter int NUM_PINS   = 8,
    parameter int CONF_WIDTH = 3
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           req_in,
    input  logic                           we_in,
    input  logic [3:0]                     addr_in,
    input  logic [31:0]                    wdata_in,
    output logic [31:0]                    rdata_out,
    output logic                           rvalid_out,
    output logic [NUM_PINS*CONF_WIDTH-1:0] cell_cfg_out,
    output logic [NUM_PINS-1:0]            from_core_out,
    input  logic [NUM_PINS-1:0]            to_core_in,
    output logic                           irq_out
);

    localparam int EW = CONF_WIDTH - 1;

    localparam logic [3:0] A_DIR      = 4'd0;
    localparam logic [3:0] A_OUT      = 4'd1;
    localparam logic [3:0] A_IN       = 4'd2;
    localparam logic [3:0] A_RISE_EN  = 4'd3;
    localparam logic [3:0] A_FALL_EN  = 4'd4;
    localparam logic [3:0] A_IRQ_EN   = 4'd5;
    localparam logic [3:0] A_IRQ_STAT = 4'd6;
    localparam logic [3:0] A_EXTRA    = 4'd7;
    localparam logic [3:0] A_OUT_SET  = 4'd8;
    localparam logic [3:0] A_OUT_CLR  = 4'd9;

    logic [NUM_PINS-1:0] dir_r;
    logic [NUM_PINS-1:0] out_r;
    logic [NUM_PINS-1:0] rise_en_r;
    logic [NUM_PINS-1:0] fall_en_r;
    logic [NUM_PINS-1:0] irq_en_r;
    logic [NUM_PINS-1:0] irq_stat_r;
    logic [EW-1:0]       extra_r;
    logic [NUM_PINS-1:0] sync1_r;
    logic [NUM_PINS-1:0] in_r;
    logic [NUM_PINS-1:0] prev_r;
    logic [1:0]          settle_cnt_r [NUM_PINS];
    logic [31:0]         rdata_r;
    logic                rvalid_r;
    logic                irq_r;

    logic                wr_s;
    logic                rd_s;
    logic [NUM_PINS-1:0] wpins_s;
    logic [NUM_PINS-1:0] settled_s;
    logic [NUM_PINS-1:0] event_s;
    logic [NUM_PINS-1:0] stat_clr_s;
    logic [31:0]         rd_mux_s;
    logic                unused_s;

    assign wr_s     = req_in & we_in;
    assign rd_s     = req_in & ~we_in;
    assign wpins_s  = wdata_in[NUM_PINS-1:0];
    assign unused_s = ^wdata_in;

    // Settle qualification and edge events; a pin that just stopped driving
    // must count down before its returning pad value can raise an event.
    always_comb begin
        settled_s = '0;
        for (int i = 0; i < NUM_PINS; i++) begin
            settled_s[i] = dir_r[i] & (settle_cnt_r[i] == 2'd0);
        end
        event_s = ((in_r & ~prev_r & rise_en_r) | (~in_r & prev_r & fall_en_r)) & settled_s;
    end

    // W1C mask for the interrupt status register.
    always_comb begin
        if (wr_s && (addr_in == A_IRQ_STAT)) begin
            stat_clr_s = wpins_s;
        end else begin
            stat_clr_s = '0;
        end
    end

    // Read data selection; write-only and unmapped addresses read as zero.
    always_comb begin
        rd_mux_s = 32'd0;
        case (addr_in)
            A_DIR:      rd_mux_s = 32'(dir_r);
            A_OUT:      rd_mux_s = 32'(out_r);
            A_IN:       rd_mux_s = 32'(in_r);
            A_RISE_EN:  rd_mux_s = 32'(rise_en_r);
            A_FALL_EN:  rd_mux_s = 32'(fall_en_r);
            A_IRQ_EN:   rd_mux_s = 32'(irq_en_r);
            A_IRQ_STAT: rd_mux_s = 32'(irq_stat_r);
            A_EXTRA:    rd_mux_s = 32'(extra_r);
            default:    rd_mux_s = 32'd0;
        endcase
    end

    // Configuration registers written from the bus.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            dir_r     <= '1;
            out_r     <= '0;
            rise_en_r <= '0;
            fall_en_r <= '0;
            irq_en_r  <= '0;
            extra_r   <= '0;
        end else if (wr_s) begin
            case (addr_in)
                A_DIR:     dir_r     <= wpins_s;
                A_OUT:     out_r     <= wpins_s;
                A_RISE_EN: rise_en_r <= wpins_s;
                A_FALL_EN: fall_en_r <= wpins_s;
                A_IRQ_EN:  irq_en_r  <= wpins_s;
                A_EXTRA:   extra_r   <= wdata_in[EW-1:0];
                A_OUT_SET: out_r     <= out_r | wpins_s;
                A_OUT_CLR: out_r     <= out_r & ~wpins_s;
                default:   out_r     <= out_r;
            endcase
        end else begin
            out_r <= out_r;
        end
    end

    // Interrupt status: a new event wins over a simultaneous clear.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            irq_stat_r <= '0;
        end else begin
            irq_stat_r <= (irq_stat_r & ~stat_clr_s) | event_s;
        end
    end

    // Two-flop synchroniser plus previous-value flop for edge detection.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sync1_r <= '0;
            in_r    <= '0;
            prev_r  <= '0;
        end else begin
            sync1_r <= to_core_in;
            in_r    <= sync1_r;
            prev_r  <= in_r;
        end
    end

    // Per-pin settle counters: reload while driving, count down once released.
    always_ff @(posedge clk_in) begin
        for (int i = 0; i < NUM_PINS; i++) begin
            if (rst_in) begin
                settle_cnt_r[i] <= 2'd0;
            end else if (!dir_r[i]) begin
                settle_cnt_r[i] <= 2'd3;
            end else if (settle_cnt_r[i] != 2'd0) begin
                settle_cnt_r[i] <= settle_cnt_r[i] - 2'd1;
            end else begin
                settle_cnt_r[i] <= 2'd0;
            end
        end
    end

    // One-cycle read response; reset drops any pending response.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rdata_r  <= 32'd0;
            rvalid_r <= 1'b0;
        end else if (rd_s) begin
            rdata_r  <= rd_mux_s;
            rvalid_r <= 1'b1;
        end else begin
            rdata_r  <= 32'd0;
            rvalid_r <= 1'b0;
        end
    end

    // Registered level interrupt.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= |(irq_stat_r & irq_en_r);
        end
    end

    // Cell configuration: shared extra bits above each pin's direction bit.
    always_comb begin
        cell_cfg_out = '0;
        for (int i = 0; i < NUM_PINS; i++) begin
            cell_cfg_out[i*CONF_WIDTH +: CONF_WIDTH] = {extra_r, dir_r[i]};
        end
    end

    assign from_core_out = out_r;
    assign rdata_out     = rdata_r;
    assign rvalid_out    = rvalid_r;
    assign irq_out       = irq_r;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Self-checking bench for gpio_pad_ctrl: directed scenarios plus a randomized
// run compared cycle by cycle against a pad-history reference model.
module tb_gpio_pad_ctrl;

    logic        clk = 1'b0;
    logic        rst, req, we;
    logic [3:0]  addr;
    logic [31:0] wdata, rdata;
    logic        rvalid, irq;
    logic [23:0] cfg;
    logic [7:0]  fc, pad;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    gpio_pad_ctrl #(.NUM_PINS(8), .CONF_WIDTH(3)) dut (
        .clk_in(clk), .rst_in(rst), .req_in(req), .we_in(we), .addr_in(addr),
        .wdata_in(wdata), .rdata_out(rdata), .rvalid_out(rvalid),
        .cell_cfg_out(cfg), .from_core_out(fc), .to_core_in(pad), .irq_out(irq)
    );

    // Reference model: registers, pad samples taken at each edge (newest first),
    // and edges elapsed since each pin last drove.
    logic [7:0]  m_dir, m_out, m_rise, m_fall, m_ien, m_stat, m_pad_hist [3];
    logic [1:0]  m_extra;
    logic [31:0] m_rdata;
    logic        m_rvalid, m_irq;
    int          m_since [8];

    function automatic logic [23:0] exp_cfg(input logic [7:0] d, input logic [1:0] e);
        logic [23:0] c = '0;
        for (int i = 0; i < 8; i++) c[i*3 +: 3] = {e, d[i]};
        return c;
    endfunction

    function void model_edge();
        logic [7:0] in_v, prev_v, settled, ev, w, clr;
        if (rst) begin
            m_dir = 8'hFF; m_out = 8'h00; m_rise = 8'h00; m_fall = 8'h00;
            m_ien = 8'h00; m_stat = 8'h00; m_extra = 2'd0;
            m_rdata = 32'd0; m_rvalid = 1'b0; m_irq = 1'b0;
            for (int i = 0; i < 3; i++) m_pad_hist[i] = 8'h00;
            for (int i = 0; i < 8; i++) m_since[i] = 3;
            return;
        end
        in_v = m_pad_hist[1];
        prev_v = m_pad_hist[2];
        for (int i = 0; i < 8; i++) settled[i] = m_dir[i] && (m_since[i] >= 3);
        ev = ((in_v & ~prev_v & m_rise) | (~in_v & prev_v & m_fall)) & settled;
        m_irq = |(m_stat & m_ien);
        m_rvalid = req && !we;
        m_rdata = 32'd0;
        if (m_rvalid) begin
            case (addr)
                4'd0: m_rdata = {24'd0, m_dir};
                4'd1: m_rdata = {24'd0, m_out};
                4'd2: m_rdata = {24'd0, in_v};
                4'd3: m_rdata = {24'd0, m_rise};
                4'd4: m_rdata = {24'd0, m_fall};
                4'd5: m_rdata = {24'd0, m_ien};
                4'd6: m_rdata = {24'd0, m_stat};
                4'd7: m_rdata = {30'd0, m_extra};
                default: m_rdata = 32'd0;
            endcase
        end
        for (int i = 0; i < 8; i++) m_since[i] = m_dir[i] ? ((m_since[i] >= 3) ? 3 : m_since[i] + 1) : 0;
        m_pad_hist[2] = m_pad_hist[1];
        m_pad_hist[1] = m_pad_hist[0];
        m_pad_hist[0] = pad;
        w = wdata[7:0];
        clr = 8'h00;
        if (req && we) begin
            case (addr)
                4'd0: m_dir = w;
                4'd1: m_out = w;
                4'd3: m_rise = w;
                4'd4: m_fall = w;
                4'd5: m_ien = w;
                4'd6: clr = w;
                4'd7: m_extra = wdata[1:0];
                4'd8: m_out = m_out | w;
                4'd9: m_out = m_out & ~w;
                default: ;
            endcase
        end
        m_stat = (m_stat & ~clr) | ev;
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d);
        req = 1'b1; we = 1'b1; addr = a; wdata = d;
        step();
        req = 1'b0; we = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] a);
        req = 1'b1; we = 1'b0; addr = a;
        step();
        req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        n_checks++;
        if ({rvalid, rdata, fc, irq} !== {1'b0, 32'd0, 8'h00, 1'b0})
            $display("FAIL reset_outputs: got rv=%b rd=%h fc=%h irq=%b want all 0", rvalid, rdata, fc, irq);
        else n_pass++;
        n_checks++;
        if (cfg !== 24'h249249) $display("FAIL reset_cfg: got %h want 249249", cfg);
        else n_pass++;
        do_read(4'd0);
        n_checks++;
        if (rvalid !== 1'b1 || rdata !== 32'h000000FF)
            $display("FAIL reset_dir_read: got rv=%b rd=%h want rv=1 rd=000000ff", rvalid, rdata);
        else n_pass++;
        step();
        n_checks++;
        if (rvalid !== 1'b0 || rdata !== 32'd0)
            $display("FAIL read_single_cycle: got rv=%b rd=%h want rv=0 rd=0", rvalid, rdata);
        else n_pass++;
    endtask

    task automatic test_outputs();
        do_write(4'd0, 32'h0000_0000);
        do_write(4'd1, 32'hFFFF_FFA5);
        do_write(4'd8, 32'h0000_0002);
        do_write(4'd9, 32'h0000_0080);
        do_write(4'd8, 32'h0000_0000);
        do_write(4'd7, 32'h0000_0003);
        n_checks++;
        if (fc !== 8'h27) $display("FAIL from_core: got %h want 27", fc);
        else n_pass++;
        n_checks++;
        if (cfg !== 24'hDB6DB6) $display("FAIL cell_cfg: got %h want db6db6", cfg);
        else n_pass++;
        do_read(4'd1);
        n_checks++;
        if (rdata !== 32'h27) $display("FAIL out_read: got %h want 27", rdata);
        else n_pass++;
        do_read(4'd8);
        n_checks++;
        if (rvalid !== 1'b1 || rdata !== 32'd0) $display("FAIL wo_read: got rv=%b rd=%h want rv=1 rd=0", rvalid, rdata);
        else n_pass++;
        do_read(4'd7);
        n_checks++;
        if (rdata !== 32'd3) $display("FAIL extra_read: got %h want 3", rdata);
        else n_pass++;
    endtask

    task automatic test_rise_irq();
        do_write(4'd0, 32'h0000_00FF);
        step(); step(); step(); step();
        do_write(4'd3, 32'h01);
        do_write(4'd5, 32'h01);
        pad[0] = 1'b1;
        step();
        do_read(4'd2);
        n_checks++;
        if (rdata !== 32'd0) $display("FAIL in_early: got %h want 0", rdata);
        else n_pass++;
        do_read(4'd2);
        n_checks++;
        if (rvalid !== 1'b1 || rdata !== 32'd1) $display("FAIL in_latency: got rv=%b rd=%h want rv=1 rd=1", rvalid, rdata);
        else n_pass++;
        n_checks++;
        if (irq !== 1'b0) $display("FAIL irq_early: got %b want 0", irq);
        else n_pass++;
        step();
        n_checks++;
        if (irq !== 1'b1) $display("FAIL irq_latency: got %b want 1", irq);
        else n_pass++;
        do_write(4'd6, 32'h01);
        n_checks++;
        if (irq !== 1'b1) $display("FAIL irq_hold_on_clear: got %b want 1", irq);
        else n_pass++;
        step();
        n_checks++;
        if (irq !== 1'b0) $display("FAIL irq_deassert: got %b want 0", irq);
        else n_pass++;
    endtask

    task automatic test_settle();
        do_write(4'd3, 32'h08);
        do_write(4'd0, 32'hF7);
        step();
        do_write(4'd0, 32'hFF);
        pad[3] = 1'b1;
        for (int i = 0; i < 12; i++) step();
        do_read(4'd6);
        n_checks++;
        if (rdata !== 32'd0) $display("FAIL settle_suppress: got %h want 0", rdata);
        else n_pass++;
        pad[3] = 1'b0;
        step(); step(); step();
        pad[3] = 1'b1;
        step(); step(); step(); step();
        do_read(4'd6);
        n_checks++;
        if (rdata !== 32'h08) $display("FAIL settle_real_edge: got %h want 08", rdata);
        else n_pass++;
    endtask

    task automatic test_fall_w1c();
        do_write(4'd4, 32'h10);
        pad[4] = 1'b1;
        step(); step(); step(); step();
        do_write(4'd6, 32'hFF);
        pad[4] = 1'b0;
        step(); step();
        do_write(4'd6, 32'h10);
        do_read(4'd6);
        n_checks++;
        if (rdata !== 32'h10) $display("FAIL set_beats_clear: got %h want 10", rdata);
        else n_pass++;
        do_write(4'd6, 32'h10);
        do_read(4'd6);
        n_checks++;
        if (rdata !== 32'h00) $display("FAIL w1c_clear: got %h want 0", rdata);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp_rst [10];
        exp_rst = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        pad = 8'h00;
        do_read(4'd0);
        n_checks++;
        if (rvalid !== 1'b1 || rdata !== 32'hFF) $display("FAIL pre_reset_read: got rv=%b rd=%h want rv=1 rd=ff", rvalid, rdata);
        else n_pass++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (rvalid !== 1'b0 || rdata !== 32'd0 || fc !== 8'h00 || cfg !== 24'h249249)
            $display("FAIL reset_mid: got rv=%b rd=%h fc=%h cfg=%h want 0/0/00/249249", rvalid, rdata, fc, cfg);
        else n_pass++;
        for (int a = 0; a < 10; a++) begin
            do_read(4'(a));
            n_checks++;
            if (rvalid !== 1'b1 || rdata !== {24'd0, exp_rst[a]})
                $display("FAIL reset_reg_%0d: got rv=%b rd=%h want rv=1 rd=%h", a, rvalid, rdata, exp_rst[a]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 0; c < 600; c++) begin
            req   = ($urandom_range(0, 2) != 0);
            we    = $urandom_range(0, 1) != 0;
            addr  = 4'($urandom_range(0, 15));
            wdata = $urandom;
            if ($urandom_range(0, 2) == 0) pad = pad ^ 8'($urandom);
            rst   = ($urandom_range(0, 99) == 0);
            step();
            n_checks++;
            if ({rvalid, rdata, cfg, fc, irq} !== {m_rvalid, m_rdata, exp_cfg(m_dir, m_extra), m_out, m_irq})
                $display("FAIL random_cycle_%0d: got rv=%b rd=%h cfg=%h fc=%h irq=%b want rv=%b rd=%h cfg=%h fc=%h irq=%b",
                         c, rvalid, rdata, cfg, fc, irq, m_rvalid, m_rdata, exp_cfg(m_dir, m_extra), m_out, m_irq);
            else n_pass++;
        end
        rst = 1'b0; req = 1'b0; we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = 4'd0; wdata = 32'd0; pad = 8'h00;
        test_reset();
        test_outputs();
        test_rise_irq();
        test_settle();
        test_fall_w1c();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gpio_pad_ctrl.md
Name: gpio_pad_ctrl

Overview:
- Core-side GPIO controller that drives a bank of bidirectional pad cells.
- Owns per-pin direction (cell cfg[0]), output value and extra cell cfg bits; receives pad input values returned by the cells.
- Synchronises inputs, detects rising/falling edges and raises a level interrupt.
- Sits between the SoC register bus and the pad ring, one instance per GPIO bank.

Parameters:
- NUM_PINS, 8, number of pad cells controlled (1..32).
- CONF_WIDTH, 3, cell cfg width; bit 0 = direction, bits [CONF_WIDTH-1:1] = extra cell cfg.

Ports:
- clk_in  input  1  system clock; all logic on rising edge.
- rst_in  input  1  synchronous active-high reset.
- req_in  input  1  register access strobe, one cycle per access.
- we_in  input  1  1 = write, 0 = read; valid with req_in.
- addr_in  input  4  word address of register.
- wdata_in  input  32  write data; bits above NUM_PINS ignored.
- rdata_out  output  32  read data, valid when rvalid_out = 1.
- rvalid_out  output  1  read response strobe.
- cell_cfg_out  output  NUM_PINS*CONF_WIDTH  per-pin cell cfg, pin i at [i*CONF_WIDTH +: CONF_WIDTH].
- from_core_out  output  NUM_PINS  drive value to cells.
- to_core_in  input  NUM_PINS  value returned by cells; asynchronous.
- irq_out  output  1  level interrupt.

Behaviour:
- Interface: one clock `clk_in`, reset `rst_in` synchronous active-high; clock and reset are the first ports.
- Register map (word address), R/W unless noted:
  - 0 DIR: 1 = input/tri-state, 0 = drive.
  - 1 OUT
  - 2 IN (RO, synchronised value)
  - 3 RISE_EN
  - 4 FALL_EN
  - 5 IRQ_EN
  - 6 IRQ_STAT (W1C)
  - 7 EXTRA: bits [CONF_WIDTH-2:0], shared by all pins
  - 8 OUT_SET (WO, OR into OUT)
  - 9 OUT_CLR (WO, AND-NOT into OUT)
  - Unmapped addresses and WO registers read 0; writes to them and to IN are ignored.
- Reset values:
  - DIR all 1 (all pads tri-stated).
  - OUT, RISE_EN, FALL_EN, IRQ_EN, IRQ_STAT, EXTRA, sync flops and settle counters: 0.
  - rdata_out = 0, rvalid_out = 0, from_core_out = 0, irq_out = 0.
- Writes take effect in the register on the clock edge where req_in & we_in. The corresponding output changes in the same cycle the register updates.
- Reads: req_in & ~we_in at edge N gives rvalid_out = 1 for exactly one cycle after edge N, with rdata_out holding the register value sampled at edge N. Otherwise rdata_out = 0 and rvalid_out = 0. Back-to-back reads each give a response.
- Cell outputs:
  - cell_cfg_out[i] = {EXTRA, DIR[i]}.
  - from_core_out[i] = OUT[i], independent of DIR.
- Input path:
  - Two-flop synchroniser per pin; IN = second stage.
  - A third flop holds the previous IN value for edge detection.
  - Latency from pad change to IN is 2 cycles; to IRQ_STAT set is 3 cycles.
- Edge qualification and settle counter:
  - Edge events are qualified by DIR[i] = 1 and the pin being settled.
  - Each pin has a 2-bit settle counter. It loads 3 on any cycle where DIR[i] = 0, and decrements to 0 while DIR[i] = 1.
  - A pin is settled when its counter = 0. This suppresses the spurious edge caused by the cell returning 0 while driving.
- Event detection:
  - Rising event: IN[i] & ~prev[i] & RISE_EN[i] & settled.
  - Falling event: ~IN[i] & prev[i] & FALL_EN[i] & settled.
  - Either event sets IRQ_STAT[i].
- IRQ_STAT clear: a write of 1 to IRQ_STAT clears the bit. If a new event occurs on the same cycle, the set wins and the bit stays 1.
- irq_out = |(IRQ_STAT & IRQ_EN), registered, so it follows IRQ_STAT by 1 cycle. Enabling IRQ_EN on an already-set bit asserts irq_out the cycle after the write.
- Simultaneous OUT_SET and OUT_CLR cannot occur (single access per cycle). OUT_SET/OUT_CLR with wdata 0 leaves OUT unchanged.
- Reset asserted mid-operation: all state returns to reset values at the next edge, and any pending read response is dropped (rvalid_out = 0).

Test Plan:
- Reset, then read DIR -> rvalid_out one cycle after req, rdata_out = 0x000000FF. cell_cfg_out pin0 = 3'b001; from_core_out = 0x00.
- Write DIR = 0x00, OUT = 0xA5, OUT_SET 0x02, OUT_CLR 0x80, EXTRA = 0x3 -> from_core_out = 0x27 and each pin cfg = 3'b110.
- DIR = 0xFF with settled pins, RISE_EN = 0x01, IRQ_EN = 0x01; pad 0 goes 0→1 at cycle T -> IN[0] = 1 at T+2, IRQ_STAT[0] = 1 at T+3, irq_out = 1 at T+4. Write IRQ_STAT 0x01 -> irq_out deasserts 1 cycle later.
- Pin 3 switched from DIR = 0 to DIR = 1 while pad held 1, RISE_EN = 0x08 -> IRQ_STAT stays 0. A real pad 1→0→1 toggle 10 cycles later sets IRQ_STAT[3].
- FALL_EN = 0x10: falling edge on pin 4 in the same cycle as a W1C write of 0x10 -> IRQ_STAT[4] remains 1.
- Reset asserted the cycle after a read request -> rvalid_out = 0 and all registers at reset values on the following read.
